// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the count-direction type.
package gray_pkg;

    localparam int unsigned CODE_W = 32;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    // Width-generic: callers zero-extend into code_t and truncate the result.
    function automatic code_t b2g(input code_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; zero-extended upper bits leave the low bits exact.
    function automatic code_t g2b(input code_t g);
        code_t b;
        for (int i = 0; i < int'(CODE_W); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/Bin2Gray.sv
// Combinational binary-to-Gray encoder.
module Bin2Gray #(
    parameter int unsigned DW = 6
) (
    input  logic [DW-1:0] bin,
    output logic [DW-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/Gray2Bin.sv
// Combinational Gray-to-binary decoder.
module Gray2Bin #(
    parameter int unsigned DW = 6
) (
    input  logic [DW-1:0] gray,
    output logic [DW-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < int'(DW); i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter with a registered, glitch-free Gray output.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned DW   = 6,
    parameter bit          WRAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [DW-1:0] load_bin,
    output logic [DW-1:0] bin,
    output logic [DW-1:0] gray,
    output logic          wrap,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW-1:0] MAX_V = '1;

    logic [DW-1:0] bin_next;
    logic [DW-1:0] gray_next;
    logic          wrap_next;

    assign at_max = (bin == MAX_V);
    assign at_min = (bin == '0);

    // Next binary count and wrap pulse; load beats en, saturation holds.
    always_comb begin
        bin_next  = bin;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (dir_e'(dir) == DIR_UP) begin
                if (at_max) begin
                    if (WRAP) begin
                        bin_next  = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin + DW'(1);
                end
            end else begin
                if (at_min) begin
                    if (WRAP) begin
                        bin_next  = MAX_V;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin - DW'(1);
                end
            end
        end
    end

    Bin2Gray #(.DW(DW)) u_b2g (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // Binary and Gray registers update together from bin_next.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
            wrap <= wrap_next;
        end
    end

    // Gray register must always be the encoding of the binary register.
    a_gray_matches_bin : assert property (@(posedge clk) disable iff (rst)
        gray == DW'(b2g(CODE_W'(bin))));

    // Outside load/reset, the Gray code moves by at most one bit per edge.
    a_gray_single_step : assert property (@(posedge clk) disable iff (rst)
        !$past(load | rst) |-> ($countones(gray ^ $past(gray)) <= 1));

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench: DW=4 wrap, DW=4 saturate, DW=6 wrap, with a Gray2Bin decoder on each.
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // a: DW=4 WRAP=1, b: DW=4 WRAP=0, c: DW=6 WRAP=1
    logic       rst_a = 1'b1, en_a = 1'b0, dir_a = 1'b0, load_a = 1'b0;
    logic [3:0] ldv_a = '0, bin_a, gray_a, re_a;
    logic       wrap_a, max_a, min_a;
    logic       rst_b = 1'b1, en_b = 1'b0, dir_b = 1'b0, load_b = 1'b0;
    logic [3:0] ldv_b = '0, bin_b, gray_b, re_b;
    logic       wrap_b, max_b, min_b;
    logic       rst_c = 1'b1, en_c = 1'b0, dir_c = 1'b0, load_c = 1'b0;
    logic [5:0] ldv_c = '0, bin_c, gray_c, re_c;
    logic       wrap_c, max_c, min_c;

    gray_counter #(.DW(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .dir(dir_a), .load(load_a), .load_bin(ldv_a),
        .bin(bin_a), .gray(gray_a), .wrap(wrap_a), .at_max(max_a), .at_min(min_a));
    gray_counter #(.DW(4), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .dir(dir_b), .load(load_b), .load_bin(ldv_b),
        .bin(bin_b), .gray(gray_b), .wrap(wrap_b), .at_max(max_b), .at_min(min_b));
    gray_counter #(.DW(6), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .dir(dir_c), .load(load_c), .load_bin(ldv_c),
        .bin(bin_c), .gray(gray_c), .wrap(wrap_c), .at_max(max_c), .at_min(min_c));

    Gray2Bin #(.DW(4)) u_g2b_a (.gray(gray_a), .bin(re_a));
    Gray2Bin #(.DW(4)) u_g2b_b (.gray(gray_b), .bin(re_b));
    Gray2Bin #(.DW(6)) u_g2b_c (.gray(gray_c), .bin(re_c));

    int n_tests = 0;
    int n_fail  = 0;
    int m_bin  [3];
    bit m_wrap [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_dut(input int sel, output logic [31:0] b, output logic [31:0] g,
                            output logic [31:0] re, output logic w, output logic mx,
                            output logic mn);
        case (sel)
            0:       begin b = 32'(bin_a); g = 32'(gray_a); re = 32'(re_a); w = wrap_a; mx = max_a; mn = min_a; end
            1:       begin b = 32'(bin_b); g = 32'(gray_b); re = 32'(re_b); w = wrap_b; mx = max_b; mn = min_b; end
            default: begin b = 32'(bin_c); g = 32'(gray_c); re = 32'(re_c); w = wrap_c; mx = max_c; mn = min_c; end
        endcase
    endtask

    // Compare one DUT against the model's current state.
    task automatic check_sel(input int sel, input string tag);
        logic [31:0] b, g, re;
        logic        w, mx, mn;
        int          maxv;
        maxv = (sel == 2) ? 63 : 15;
        read_dut(sel, b, g, re, w, mx, mn);
        chk({tag, "_bin"},    b,  32'(m_bin[sel]));
        chk({tag, "_gray"},   g,  32'(m_bin[sel] ^ (m_bin[sel] / 2)));
        chk({tag, "_wrap"},   32'(w),  32'(m_wrap[sel]));
        chk({tag, "_at_max"}, 32'(mx), 32'(m_bin[sel] == maxv));
        chk({tag, "_at_min"}, 32'(mn), 32'(m_bin[sel] == 0));
        chk({tag, "_bin_re"}, re, 32'(m_bin[sel]));
    endtask

    // Drive one DUT for one edge (others idle), advance the model, check.
    task automatic step(input int sel, input bit r, input bit ld, input int ldv,
                        input bit e, input bit d, input string tag);
        int          span, b, nb;
        bit          wm, nw;
        logic [31:0] pb, pg, pre, ng;
        logic        pw, pmx, pmn;
        span = (sel == 2) ? 64 : 16;
        wm   = (sel != 1);
        read_dut(sel, pb, pg, pre, pw, pmx, pmn);
        {rst_a, load_a, en_a, rst_b, load_b, en_b, rst_c, load_c, en_c} = '0;
        case (sel)
            0:       begin rst_a = r; load_a = ld; ldv_a = 4'(ldv); en_a = e; dir_a = d; end
            1:       begin rst_b = r; load_b = ld; ldv_b = 4'(ldv); en_b = e; dir_b = d; end
            default: begin rst_c = r; load_c = ld; ldv_c = 6'(ldv); en_c = e; dir_c = d; end
        endcase
        b  = m_bin[sel];
        nb = b;
        nw = 1'b0;
        if (r) begin
            nb = 0;
        end else if (ld) begin
            nb = ldv % span;
        end else if (e && d) begin
            if (b + 1 == span) begin
                nb = wm ? 0 : b;
                nw = wm;
            end else nb = b + 1;
        end else if (e) begin
            if (b == 0) begin
                nb = wm ? span - 1 : 0;
                nw = wm;
            end else nb = b - 1;
        end
        tick();
        m_bin[sel]  = nb;
        m_wrap[sel] = nw;
        check_sel(sel, tag);
        if (!r && !ld) begin
            read_dut(sel, pb, ng, pre, pw, pmx, pmn);
            chk({tag, "_gray_bits"}, 32'($countones(ng ^ pg)), 32'(nb != b));
        end
    endtask

    initial begin
        logic [31:0] b, g, re;
        logic        w, mx, mn;

        // 1: reset all, then count up a full lap on DUT a.
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            m_bin[s]  = 0;
            m_wrap[s] = 1'b0;
            check_sel(s, "reset");
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 1, "t1_up");
        read_dut(0, b, g, re, w, mx, mn);
        chk("t1_lap_end_gray", g, 32'h0);

        // 2: from reset, one step down wraps to max.
        step(0, 1, 0, 0, 0, 0, "t2_rst");
        step(0, 0, 0, 0, 1, 0, "t2_down");
        read_dut(0, b, g, re, w, mx, mn);
        chk("t2_bin", b, 32'hF);
        chk("t2_gray", g, 32'b1000);
        chk("t2_wrap", 32'(w), 32'h1);
        chk("t2_at_max", 32'(mx), 32'h1);

        // 3: load wins over en, then one step up.
        step(0, 0, 1, 9, 1, 1, "t3_load");
        read_dut(0, b, g, re, w, mx, mn);
        chk("t3_load_gray", g, 32'b1101);
        step(0, 0, 0, 0, 1, 1, "t3_up");
        read_dut(0, b, g, re, w, mx, mn);
        chk("t3_up_gray", g, 32'b1111);

        // 4: saturating DUT holds at both ends.
        step(1, 0, 1, 15, 0, 0, "t4_load15");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, "t4_sat_up");
        read_dut(1, b, g, re, w, mx, mn);
        chk("t4_sat_gray", g, 32'b1000);
        step(1, 0, 1, 0, 0, 0, "t4_load0");
        step(1, 0, 0, 0, 1, 0, "t4_sat_down");
        step(1, 0, 0, 0, 1, 0, "t4_sat_down2");

        // 5: reset mid-count with en high, then resume.
        step(0, 1, 0, 0, 0, 0, "t5_rst");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1, "t5_up");
        step(0, 1, 0, 0, 1, 1, "t5_rst_en");
        step(0, 0, 0, 0, 1, 1, "t5_resume");
        read_dut(0, b, g, re, w, mx, mn);
        chk("t5_resume_bin", b, 32'h1);

        // 6: random traffic on the DW=6 counter.
        for (int i = 0; i < 2000; i++) begin
            step(2, ($urandom_range(99) == 0), ($urandom_range(9) == 0),
                 int'($urandom_range(63)), 1'($urandom), 1'($urandom), "t6_rand");
        end
        // Hit both wrap boundaries explicitly on the wide counter.
        step(2, 0, 1, 63, 0, 0, "t6_load63");
        step(2, 0, 0, 0, 1, 1, "t6_wrap_up");
        step(2, 0, 0, 0, 1, 0, "t6_wrap_down");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
